// File: rtl/fml_arb2_pkg.sv
// Shared constants for the two-master FML 4x64 arbiter.
package fml_arb2_pkg;

    localparam int FML_BEATS = 4;
    localparam int FML_DW    = 64;
    localparam int FML_SELW  = 8;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    typedef enum logic {
        ST_GNT_M0 = 1'b0,
        ST_GNT_M1 = 1'b1
    } grant_e;

    function automatic grant_e otherMaster(input grant_e g);
        return (g == ST_GNT_M0) ? ST_GNT_M1 : ST_GNT_M0;
    endfunction

endpackage

// File: rtl/fml_arb2_wdata.sv
// Write-data window: after a write eack, steers BURST_LEN beats of di/sel
// from the master that owned that burst.
module fml_arb2_wdata
    import fml_arb2_pkg::*;
#(
    parameter int BURST_LEN = FML_BEATS
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic                i_owner,
    input  logic [FML_DW-1:0]   i_m0_di,
    input  logic [FML_SELW-1:0] i_m0_sel,
    input  logic [FML_DW-1:0]   i_m1_di,
    input  logic [FML_SELW-1:0] i_m1_sel,
    output logic [FML_DW-1:0]   o_s_di,
    output logic [FML_SELW-1:0] o_s_sel
);

    localparam int CW = $clog2(BURST_LEN + 1);

    logic [CW-1:0] r_wcnt;
    logic          r_wown;
    logic          w_active;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wcnt <= '0;
            r_wown <= GNT_M0;
        end else if (i_load) begin
            r_wcnt <= CW'(BURST_LEN);
            r_wown <= i_owner;
        end else if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - CW'(1);
        end
    end

    assign w_active = (r_wcnt != '0);

    // Byte enables must be quiet outside the window so the controller never
    // sees a stray write beat; data itself is a don't-care there.
    always_comb begin
        o_s_di  = (r_wown == GNT_M1) ? i_m1_di : i_m0_di;
        o_s_sel = '0;
        if (w_active) begin
            o_s_sel = (r_wown == GNT_M1) ? i_m1_sel : i_m0_sel;
        end
    end

endmodule

// File: rtl/fml_arb2.sv
// Two-master, one-slave FML 4x64 arbiter: round-robin address-phase grant,
// eack routing and write-data steering. Define FML_ARB_FIXED_PRIO_EN for
// strict master-0 priority instead of round-robin.
module fml_arb2
    import fml_arb2_pkg::*;
#(
    parameter int SDRAM_DEPTH = 26,
    parameter int BURST_LEN   = FML_BEATS
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,

    input  logic [SDRAM_DEPTH-1:0] m0_adr,
    input  logic                   m0_stb,
    input  logic                   m0_we,
    output logic                   m0_eack,
    input  logic [FML_SELW-1:0]    m0_sel,
    input  logic [FML_DW-1:0]      m0_di,
    output logic [FML_DW-1:0]      m0_do,

    input  logic [SDRAM_DEPTH-1:0] m1_adr,
    input  logic                   m1_stb,
    input  logic                   m1_we,
    output logic                   m1_eack,
    input  logic [FML_SELW-1:0]    m1_sel,
    input  logic [FML_DW-1:0]      m1_di,
    output logic [FML_DW-1:0]      m1_do,

    output logic [SDRAM_DEPTH-1:0] s_adr,
    output logic                   s_stb,
    output logic                   s_we,
    input  logic                   s_eack,
    output logic [FML_SELW-1:0]    s_sel,
    output logic [FML_DW-1:0]      s_di,
    input  logic [FML_DW-1:0]      s_do
);

    grant_e r_grant;
    grant_e w_grant_next;
    logic   w_cur_stb;
    logic   w_oth_stb;
    logic   w_owner;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_grant <= ST_GNT_M0;
        end else begin
            r_grant <= w_grant_next;
        end
    end

    assign w_cur_stb = (r_grant == ST_GNT_M1) ? m1_stb : m0_stb;
    assign w_oth_stb = (r_grant == ST_GNT_M1) ? m0_stb : m1_stb;

    // A live request is never preempted; the grant only moves on eack or
    // when the grantee has gone idle.
    always_comb begin
        w_grant_next = r_grant;
`ifdef FML_ARB_FIXED_PRIO_EN
        if (s_eack || !w_cur_stb) begin
            if (m0_stb) begin
                w_grant_next = ST_GNT_M0;
            end else if (m1_stb) begin
                w_grant_next = ST_GNT_M1;
            end
        end
`else
        if (s_eack || !w_cur_stb) begin
            if (w_oth_stb) begin
                w_grant_next = otherMaster(r_grant);
            end
        end
`endif
    end

    assign w_owner = (r_grant == ST_GNT_M1) ? GNT_M1 : GNT_M0;

    always_comb begin
        s_adr   = (r_grant == ST_GNT_M1) ? m1_adr : m0_adr;
        s_we    = (r_grant == ST_GNT_M1) ? m1_we  : m0_we;
        s_stb   = w_cur_stb & sys_rst_n;
        m0_eack = s_eack & sys_rst_n & (r_grant == ST_GNT_M0);
        m1_eack = s_eack & sys_rst_n & (r_grant == ST_GNT_M1);
    end

    assign m0_do = s_do;
    assign m1_do = s_do;

    fml_arb2_wdata #(
        .BURST_LEN (BURST_LEN)
    ) u_wdata (
        .i_clk    (sys_clk),
        .i_rst_n  (sys_rst_n),
        .i_load   (s_eack & s_we),
        .i_owner  (w_owner),
        .i_m0_di  (m0_di),
        .i_m0_sel (m0_sel),
        .i_m1_di  (m1_di),
        .i_m1_sel (m1_sel),
        .o_s_di   (s_di),
        .o_s_sel  (s_sel)
    );

endmodule

// File: tb/tb_fml_arb2.sv
// Directed self-checking bench for fml_arb2 (honours FML_ARB_FIXED_PRIO_EN).
module tb_fml_arb2;

    logic        clk = 1'b0;
    logic        rstN;
    logic [25:0] m0Adr, m1Adr;
    logic        m0Stb, m0We, m1Stb, m1We;
    logic        m0Eack, m1Eack;
    logic [7:0]  m0Sel, m1Sel;
    logic [63:0] m0Di, m1Di, m0Do, m1Do;
    logic [25:0] sAdr;
    logic        sStb, sWe, sEack;
    logic [7:0]  sSel;
    logic [63:0] sDi, sDo;

    int total = 0;
    int bad   = 0;
    bit fixedPrio;
    logic [63:0] beatData;
    logic [7:0]  beatSel;
    logic        expOwner;

    always #5 clk = ~clk;

    fml_arb2 dut (
        .sys_clk   (clk),
        .sys_rst_n (rstN),
        .m0_adr    (m0Adr),
        .m0_stb    (m0Stb),
        .m0_we     (m0We),
        .m0_eack   (m0Eack),
        .m0_sel    (m0Sel),
        .m0_di     (m0Di),
        .m0_do     (m0Do),
        .m1_adr    (m1Adr),
        .m1_stb    (m1Stb),
        .m1_we     (m1We),
        .m1_eack   (m1Eack),
        .m1_sel    (m1Sel),
        .m1_di     (m1Di),
        .m1_do     (m1Do),
        .s_adr     (sAdr),
        .s_stb     (sStb),
        .s_we      (sWe),
        .s_eack    (sEack),
        .s_sel     (sSel),
        .s_di      (sDi),
        .s_do      (sDo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic stb0, input logic we0,
                                 input logic stb1, input logic we1, input logic eack);
        rstN  = rst;
        m0Stb = stb0;
        m0We  = we0;
        m1Stb = stb1;
        m1We  = we1;
        sEack = eack;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
`ifdef FML_ARB_FIXED_PRIO_EN
        fixedPrio = 1'b1;
`else
        fixedPrio = 1'b0;
`endif
        m0Adr = 26'h0000100; m1Adr = 26'h0000200;
        m0Sel = 8'h00; m1Sel = 8'h00;
        m0Di = 64'h0; m1Di = 64'h0; sDo = 64'h0;

        // 1: reset held three cycles with both masters requesting
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_s_stb", sStb, 0);
            checkOutput("rst_s_sel", sSel, 0);
            checkOutput("rst_m0_eack", m0Eack, 0);
            checkOutput("rst_m1_eack", m1Eack, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rel_s_stb", sStb, 1);
        checkOutput("rel_s_adr", sAdr, 26'h0000100);
        tick();

        // 2: m0 write burst, beats follow eack
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("w0_m0_eack", m0Eack, 1);
        checkOutput("w0_m1_eack", m1Eack, 0);
        checkOutput("w0_s_we", sWe, 1);
        checkOutput("w0_s_sel_pre", sSel, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            beatData = 64'hD0D0_0000_0000_0000 + 64'(b);
            m0Di = beatData; m0Sel = 8'hFF;
            m1Di = 64'hBAD0_BAD0_BAD0_BAD0; m1Sel = 8'h11;
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("w0_s_di", sDi, beatData);
            checkOutput("w0_s_sel", sSel, 8'hFF);
            tick();
        end
        #1;
        checkOutput("w0_s_sel_end", sSel, 0);

        // 3: both requesting continuously, slave eacks every 6 cycles
        m0Adr = 26'h0000100; m1Adr = 26'h0000200;
        for (int k = 0; k < 4; k++) begin
            expOwner = fixedPrio ? 1'b0 : k[0];
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("rr_s_adr", sAdr, expOwner ? 26'h0000200 : 26'h0000100);
            for (int c = 0; c < 5; c++) tick();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("rr_m0_eack", m0Eack, !expOwner);
            checkOutput("rr_m1_eack", m1Eack, expOwner);
            tick();
        end

        // 4: m1 read, then m0 write; read eack must not open a write window
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rw_bubble_stb", sStb, 0);
        tick();
        sDo = 64'h1234_5678_9ABC_DEF0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("rw_m1_eack", m1Eack, 1);
        checkOutput("rw_m0_eack_rd", m0Eack, 0);
        checkOutput("rw_s_adr_rd", sAdr, 26'h0000200);
        checkOutput("rw_m0_do", m0Do, 64'h1234_5678_9ABC_DEF0);
        checkOutput("rw_m1_do", m1Do, 64'h1234_5678_9ABC_DEF0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rw_sel_after_rd", sSel, 0);
        checkOutput("rw_s_adr_wr", sAdr, 26'h0000100);
        checkOutput("rw_m1_eack_once", m1Eack, 0);
        tick(); tick(); tick();
        checkOutput("rw_sel_idle", sSel, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rw_m0_eack", m0Eack, 1);
        checkOutput("rw_m1_eack_wr", m1Eack, 0);
        tick();
        for (int b = 0; b < 4; b++) begin
            beatData = 64'hC0DE_0000_0000_0010 + 64'(b);
            beatSel = 8'h0F ^ 8'(b);
            m0Di = beatData; m0Sel = beatSel;
            m1Di = 64'hFFFF_0000_FFFF_0000; m1Sel = 8'hF0;
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("rw_s_di", sDi, beatData);
            checkOutput("rw_s_sel", sSel, beatSel);
            tick();
        end
        #1;
        checkOutput("rw_s_sel_end", sSel, 0);

        // 5: m0 drops stb without eack while m1 requests
        m0Adr = 26'h0000300; m1Adr = 26'h0000400;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_s_adr0", sAdr, 26'h0000300);
        checkOutput("drop_s_stb0", sStb, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_bubble", sStb, 0);
        tick();
        checkOutput("drop_s_adr1", sAdr, 26'h0000400);
        checkOutput("drop_s_stb1", sStb, 1);

        // 6: reset during beat 2 of an m1 write
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("rb_m1_eack", m1Eack, 1);
        checkOutput("rb_s_we", sWe, 1);
        tick();
        m1Di = 64'hB1; m1Sel = 8'hAA; m0Di = 64'h55; m0Sel = 8'h33;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rb_beat1_di", sDi, 64'hB1);
        checkOutput("rb_beat1_sel", sSel, 8'hAA);
        tick();
        m1Di = 64'hB2;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rb_beat2_sel", sSel, 8'hAA);
        tick();
        checkOutput("rb_sel_cut", sSel, 0);
        checkOutput("rb_s_stb", sStb, 0);
        m0Adr = 26'h0000500;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rb_s_adr", sAdr, 26'h0000500);
        checkOutput("rb_sel_stays", sSel, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("rb_m0_eack", m0Eack, 1);
        checkOutput("rb_m1_eack", m1Eack, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rb_no_resume", sSel, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
